decrypt_phase_sched: RTL

//  Sequences the ROLLO-I decryption engines: gf2mz (s=c*x), S1S2 generation, RSR (gs_elim) and SHA3.

---
 rtl/decrypt_phase_sched_pkg.sv | 32 +++
 rtl/decrypt_phase_sched_s1s2_port_arb.sv | 77 +++++++
 rtl/decrypt_phase_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decrypt_phase_sched_pkg.sv
// Shared phase codes and small helpers for the ROLLO-I decryption phase scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decrypt_phase_sched_pkg;

  // Phase code exported on status and used as the S1S2 port-mux key.
  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_MUL  = 3'd1,
    PH_GEN  = 3'd2,
    PH_RSR  = 3'd3,
    PH_HASH = 3'd4,
    PH_DONE = 3'd5,
    PH_ERR  = 3'd6
  } phase_e;

  // Read latency engines see on mem_S1S2: one cycle in the port mux register plus the RAM.
  localparam int DELAY_RD_S1S2 = 2;

  localparam logic [31:0] CYC_SAT = 32'hFFFF_FFFF;

  // True for the four phases in which an engine is running.
  function automatic logic is_engine_phase(input phase_e ph);
    return (ph == PH_MUL) || (ph == PH_GEN) || (ph == PH_RSR) || (ph == PH_HASH);
  endfunction

  // Saturating increment for the total cycle counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == CYC_SAT) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/decrypt_phase_sched_s1s2_port_arb.sv
// S1S2 memory port arbiter: picks the S1S2gen, RSR or SHA3 request according to the current phase.
// Latency: one registered cycle from request to mem_S1S2 port (two cycles for read data incl. RAM).
// Backpressure: none; requests from engines not owning the phase are dropped (addr/we/di forced to 0).
module decrypt_phase_sched_s1s2_port_arb
  import decrypt_phase_sched_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  input  phase_e        status_i,
  input  logic [AW-1:0] gen_addr_i,
  input  logic          gen_we_i,
  input  logic [DW-1:0] gen_di_i,
  input  logic [AW-1:0] rsr_addr_i,
  input  logic          rsr_we_i,
  input  logic [DW-1:0] rsr_di_i,
  input  logic [AW-1:0] sha_addr_i,
  input  logic          sha_we_i,
  output logic [AW-1:0] s12_addr_o,
  output logic          s12_we_o,
  output logic [DW-1:0] s12_di_o
);

  logic [AW-1:0] addr_d, addr_q;
  logic          we_d, we_q;
  logic [DW-1:0] di_d, di_q;

  // Select the requester owning the phase of this very cycle, so no write crosses a phase boundary.
  always_comb begin
    addr_d = '0;
    we_d   = 1'b0;
    di_d   = '0;
    case (status_i)
      PH_GEN: begin
        addr_d = gen_addr_i;
        we_d   = gen_we_i;
        di_d   = gen_di_i;
      end
      PH_RSR: begin
        addr_d = rsr_addr_i;
        we_d   = rsr_we_i;
        di_d   = rsr_di_i;
      end
      PH_HASH: begin
        // SHA3 only reads S1S2; its write data is tied low.
        addr_d = sha_addr_i;
        we_d   = sha_we_i;
        di_d   = '0;
      end
      default: begin
        addr_d = '0;
        we_d   = 1'b0;
        di_d   = '0;
      end
    endcase
  end

  // Port register towards mem_S1S2.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      di_q   <= '0;
    end else begin
      addr_q <= addr_d;
      we_q   <= we_d;
      di_q   <= di_d;
    end
  end

  assign s12_addr_o = addr_q;
  assign s12_we_o   = we_q;
  assign s12_di_o   = di_q;

endmodule

// File: rtl/decrypt_phase_sched.sv
// Decryption phase scheduler: gf2mz -> S1S2gen -> RSR -> SHA3, with per-phase watchdog and cycle count.
// Latency: engine start pulse in the first cycle of its phase; next phase one cycle after a valid done.
// Backpressure: none; start is dropped unless IDLE/ERR, dones from non-owning engines are ignored.
module decrypt_phase_sched
  import decrypt_phase_sched_pkg::*;
#(
  parameter int              M      = 8,
  parameter int              N      = 16,
  parameter int              AW     = $clog2(2*N),
  parameter int              TO_W   = 20,
  parameter logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  output logic            finish,
  output logic            error,
  output logic            busy,
  output logic [2:0]      status,
  output logic            gf2mz_start,
  input  logic            gf2mz_done,
  output logic            S1S2gen_start,
  input  logic            S1S2gen_done,
  output logic            RSR_start,
  input  logic            RSR_done,
  output logic            sha3_start,
  input  logic            sha3_done,
  input  logic [AW-1:0]   gen_addr,
  input  logic            gen_we,
  input  logic [2*M-1:0]  gen_di,
  input  logic [AW-1:0]   rsr_addr,
  input  logic            rsr_we,
  input  logic [2*M-1:0]  rsr_di,
  input  logic [AW-1:0]   sha_addr,
  input  logic            sha_we,
  output logic [AW-1:0]   s12_addr,
  output logic            s12_we,
  output logic [2*M-1:0]  s12_di,
  output logic [31:0]     cyc_total
);

  // Watchdog value in the last allowed cycle of a phase.
  localparam logic [TO_W-1:0] WD_LAST = TO_MAX - 1'b1;

  phase_e          state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [31:0]     cyc_q, cyc_d;
  logic            gf2mz_start_q, s1s2gen_start_q, rsr_start_q, sha3_start_q;
  logic            finish_q, error_q, busy_q;

  logic            owner_done;
  logic            start_pulse;
  logic            phase_done;
  logic            in_phase;
  logic            wd_expired;
  logic            start_acc;
  logic            phase_change;

  // The start pulse marks the first cycle of a phase; a done seen then belongs to the previous run.
  assign start_pulse = gf2mz_start_q | s1s2gen_start_q | rsr_start_q | sha3_start_q;
  assign in_phase    = is_engine_phase(state_q);
  assign wd_expired  = in_phase && (wd_q == WD_LAST);
  assign start_acc   = start && ((state_q == PH_IDLE) || (state_q == PH_ERR));
  assign phase_done  = owner_done && !start_pulse;

  // Only the engine owning the current phase may advance it.
  always_comb begin
    owner_done = 1'b0;
    case (state_q)
      PH_MUL:  owner_done = gf2mz_done;
      PH_GEN:  owner_done = S1S2gen_done;
      PH_RSR:  owner_done = RSR_done;
      PH_HASH: owner_done = sha3_done;
      default: owner_done = 1'b0;
    endcase
  end

  // Next phase; a valid done wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_IDLE: if (start_acc) state_d = PH_MUL;
      PH_MUL: begin
        if (phase_done)      state_d = PH_GEN;
        else if (wd_expired) state_d = PH_ERR;
      end
      PH_GEN: begin
        if (phase_done)      state_d = PH_RSR;
        else if (wd_expired) state_d = PH_ERR;
      end
      PH_RSR: begin
        if (phase_done)      state_d = PH_HASH;
        else if (wd_expired) state_d = PH_ERR;
      end
      PH_HASH: begin
        if (phase_done)      state_d = PH_DONE;
        else if (wd_expired) state_d = PH_ERR;
      end
      PH_DONE: state_d = PH_IDLE;
      PH_ERR:  if (start_acc) state_d = PH_MUL;
      default: state_d = PH_IDLE;
    endcase
  end

  assign phase_change = (state_d != state_q);

  // Watchdog restarts at every phase change and only runs while an engine owns the phase.
  always_comb begin
    if (phase_change || !in_phase) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Total cycle count: restart on accepted start, count every non-idle cycle, hold once idle.
  always_comb begin
    if (start_acc) begin
      cyc_d = '0;
    end else if (state_q != PH_IDLE) begin
      cyc_d = sat_inc32(cyc_q);
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Phase register plus registered outputs decoded from the next phase.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q         <= PH_IDLE;
      wd_q            <= '0;
      cyc_q           <= '0;
      gf2mz_start_q   <= 1'b0;
      s1s2gen_start_q <= 1'b0;
      rsr_start_q     <= 1'b0;
      sha3_start_q    <= 1'b0;
      finish_q        <= 1'b0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wd_q            <= wd_d;
      cyc_q           <= cyc_d;
      gf2mz_start_q   <= phase_change && (state_d == PH_MUL);
      s1s2gen_start_q <= phase_change && (state_d == PH_GEN);
      rsr_start_q     <= phase_change && (state_d == PH_RSR);
      sha3_start_q    <= phase_change && (state_d == PH_HASH);
      finish_q        <= (state_d == PH_DONE);
      error_q         <= (state_d == PH_ERR);
      busy_q          <= (state_d != PH_IDLE);
    end
  end

  assign status        = state_q;
  assign busy          = busy_q;
  assign finish        = finish_q;
  assign error         = error_q;
  assign gf2mz_start   = gf2mz_start_q;
  assign S1S2gen_start = s1s2gen_start_q;
  assign RSR_start     = rsr_start_q;
  assign sha3_start    = sha3_start_q;
  assign cyc_total     = cyc_q;

  decrypt_phase_sched_s1s2_port_arb #(
    .AW (AW),
    .DW (2*M)
  ) u_port_arb (
    .clk        (clk),
    .rst_b      (rst_b),
    .status_i   (state_q),
    .gen_addr_i (gen_addr),
    .gen_we_i   (gen_we),
    .gen_di_i   (gen_di),
    .rsr_addr_i (rsr_addr),
    .rsr_we_i   (rsr_we),
    .rsr_di_i   (rsr_di),
    .sha_addr_i (sha_addr),
    .sha_we_i   (sha_we),
    .s12_addr_o (s12_addr),
    .s12_we_o   (s12_we),
    .s12_di_o   (s12_di)
  );

endmodule
